// File: rtl/mc_seq.sv
// rtl/mc_seq.sv - multi-cycle RV32I sequencer with wait-state handshakes, faults and counters
module mc_seq #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic             Zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             IMemReq,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [2:0]       State,
  output logic             Retire,
  output logic [1:0]       Fault,
  output logic [CNT_W-1:0] RetireCnt,
  output logic [CNT_W-1:0] CycleCnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R     = 3'd0,
    C_IALU  = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_BR    = 3'd4,
    C_JAL   = 3'd5,
    C_JALR  = 3'd6,
    C_LUI   = 3'd7
  } class_t;

  localparam logic [7:0] W_MAX = 8'(WAIT_MAX);

  state_t           r_state;
  state_t           w_next;
  class_t           r_class;
  class_t           w_dec_class;
  logic             w_dec_legal;
  logic [7:0]       r_wait;
  logic             w_wait_hit;
  logic             w_waiting;
  logic [1:0]       r_fault;
  logic [1:0]       w_next_fault;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             w_unused;

  // Branch resolution lives in NPC; the flag is accepted but not used here
  assign w_unused = Zero;

  assign w_wait_hit = (r_wait == W_MAX);
  assign w_waiting  = ((r_state == S_IF)  && !imem_ready) ||
                      ((r_state == S_MEM) && !dmem_ready);

  // Map the opcode onto one of the eight supported instruction classes
  always_comb begin
    w_dec_legal = 1'b1;
    w_dec_class = C_R;
    case (Op)
      7'b0110011: w_dec_class = C_R;
      7'b0010011: w_dec_class = C_IALU;
      7'b0000011: w_dec_class = C_LOAD;
      7'b0100011: w_dec_class = C_STORE;
      7'b1100011: w_dec_class = C_BR;
      7'b1101111: w_dec_class = C_JAL;
      7'b1100111: w_dec_class = C_JALR;
      7'b0110111: w_dec_class = C_LUI;
      default:    w_dec_legal = 1'b0;
    endcase
  end

  // State register; any reset restarts at fetch with nothing committed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // Next-state and fault selection; a late ready beats the timeout
  always_comb begin
    w_next       = r_state;
    w_next_fault = r_fault;
    case (r_state)
      S_IF: begin
        if (imem_ready) begin
          w_next = S_ID;
        end else if (w_wait_hit) begin
          w_next       = S_HALT;
          w_next_fault = 2'b10;
        end
      end
      S_ID: begin
        if (w_dec_legal) begin
          w_next = S_EX;
        end else begin
          w_next       = S_HALT;
          w_next_fault = 2'b01;
        end
      end
      S_EX: begin
        case (r_class)
          C_BR:             w_next = S_IF;
          C_LOAD, C_STORE:  w_next = S_MEM;
          default:          w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          w_next = (r_class == C_LOAD) ? S_WB : S_IF;
        end else if (w_wait_hit) begin
          w_next       = S_HALT;
          w_next_fault = 2'b11;
        end
      end
      S_WB:    w_next = S_IF;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // Strobes decoded from state, latched class and the ready inputs
  always_comb begin
    IMemReq  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Retire   = 1'b0;
    case (r_state)
      S_IF: begin
        IMemReq = 1'b1;
        IRWrite = imem_ready;
      end
      S_EX: begin
        PCWrite = (r_class == C_BR);
        Retire  = (r_class == C_BR);
      end
      S_MEM: begin
        MemRead  = (r_class == C_LOAD);
        MemWrite = (r_class == C_STORE);
        PCWrite  = (r_class == C_STORE) && dmem_ready;
        Retire   = (r_class == C_STORE) && dmem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        Retire   = 1'b1;
      end
      default: ;
    endcase
  end

  // Class is captured only when a legal opcode is decoded
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                r_class <= C_R;
    else if ((r_state == S_ID) && w_dec_legal) r_class <= w_dec_class;
  end

  // Wait counter restarts on every state change and saturates at the limit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         r_wait <= 8'd0;
    else if (w_next != r_state)        r_wait <= 8'd0;
    else if (w_waiting && !w_wait_hit) r_wait <= r_wait + 8'd1;
  end

  // Fault code is sticky once HALT is entered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_fault <= 2'b00;
    else       r_fault <= w_next_fault;
  end

  // Retire and cycle counters; both freeze in HALT and wrap silently
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_retire_cnt <= '0;
      r_cycle_cnt  <= '0;
    end else begin
      if (Retire)            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (r_state != S_HALT) r_cycle_cnt  <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign State     = r_state;
  assign Fault     = r_fault;
  assign RetireCnt = r_retire_cnt;
  assign CycleCnt  = r_cycle_cnt;

endmodule

// File: tb/tb_mc_seq.sv
// tb/tb_mc_seq.sv - randomized self-checking bench for mc_seq against an instruction-level model
module tb_mc_seq;

  localparam int WAIT_MAX = 15;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b0001111;
  localparam logic [6:0] LEGAL_OPS [8] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI};

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  Op;
  logic        Zero;
  logic        imem_ready;
  logic        dmem_ready;

  logic        IMemReq, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Retire;
  logic [2:0]  State;
  logic [1:0]  Fault;
  logic [31:0] RetireCnt, CycleCnt;

  logic        IMemReq4, IRWrite4, PCWrite4, RegWrite4, MemRead4, MemWrite4, Retire4;
  logic [2:0]  State4;
  logic [1:0]  Fault4;
  logic [3:0]  RetireCnt4, CycleCnt4;

  mc_seq #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) u_dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemReq(IMemReq), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .State(State), .Retire(Retire),
    .Fault(Fault), .RetireCnt(RetireCnt), .CycleCnt(CycleCnt)
  );

  mc_seq #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .Op(Op), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemReq(IMemReq4), .IRWrite(IRWrite4), .PCWrite(PCWrite4), .RegWrite(RegWrite4),
    .MemRead(MemRead4), .MemWrite(MemWrite4), .State(State4), .Retire(Retire4),
    .Fault(Fault4), .RetireCnt(RetireCnt4), .CycleCnt(CycleCnt4)
  );

  always #5 clk = ~clk;

  // vec = {State[2:0], IMemReq, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Retire, Fault[1:0]}
  typedef struct packed {
    logic [11:0] vec;
    logic [31:0] ret;
    logic [31:0] cyc;
  } obs_t;

  typedef struct packed {
    logic [11:0] vec;
    logic [3:0]  ret;
    logic [3:0]  cyc;
  } obs4_t;

  typedef struct {
    logic [6:0] op;
    logic       ir;
    logic       dr;
    obs_t       exp;
    obs4_t      exp4;
  } cyc_t;

  cyc_t  trace[$];
  obs_t  obs_q[$];
  obs4_t obs4_q[$];

  logic [31:0] m_ret;
  logic [31:0] m_cyc;
  logic [1:0]  m_fault;
  bit          m_halted;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    trace.delete();
    m_ret    = 32'd0;
    m_cyc    = 32'd0;
    m_fault  = 2'b00;
    m_halted = 1'b0;
  endtask

  task automatic push(input logic [6:0] op, input logic ir, input logic dr, input logic [2:0] st,
                      input logic imreq, input logic irw, input logic pcw, input logic rw,
                      input logic mr, input logic mw, input logic rt);
    cyc_t c;
    c.op       = op;
    c.ir       = ir;
    c.dr       = dr;
    c.exp.vec  = {st, imreq, irw, pcw, rw, mr, mw, rt, m_fault};
    c.exp.ret  = m_ret;
    c.exp.cyc  = m_cyc;
    c.exp4.vec = c.exp.vec;
    c.exp4.ret = m_ret[3:0];
    c.exp4.cyc = m_cyc[3:0];
    trace.push_back(c);
    if (st != 3'd5) m_cyc = m_cyc + 32'd1;
    if (rt)         m_ret = m_ret + 32'd1;
  endtask

  task automatic push_halt(input logic [6:0] op, input int n);
    for (int k = 0; k < n; k++)
      push(op, 1'($urandom), 1'($urandom), 3'd5, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One instruction: iw/dw are wait cycles before the memory answers; beyond WAIT_MAX it never does
  task automatic model_instr(input logic [6:0] op, input int iw, input int dw, input int tail);
    int   n;
    logic rd;
    bit   legal, is_ld, is_st, is_br;
    is_ld = (op == OP_LD);
    is_st = (op == OP_ST);
    is_br = (op == OP_BR);
    legal = 1'b0;
    for (int k = 0; k < 8; k++) if (LEGAL_OPS[k] == op) legal = 1'b1;
    if (m_halted) begin
      push_halt(op, tail);
      return;
    end
    n = (iw > WAIT_MAX) ? WAIT_MAX + 1 : iw + 1;
    for (int k = 0; k < n; k++) begin
      rd = (k == iw);
      push(op, rd, 1'($urandom), 3'd0, 1, rd, 0, 0, 0, 0, 0);
    end
    if (iw > WAIT_MAX) begin
      m_fault = 2'b10; m_halted = 1'b1; push_halt(op, tail);
      return;
    end
    push(op, 1'($urandom), 1'($urandom), 3'd1, 0, 0, 0, 0, 0, 0, 0);
    if (!legal) begin
      m_fault = 2'b01; m_halted = 1'b1; push_halt(op, tail);
      return;
    end
    push(op, 1'($urandom), 1'($urandom), 3'd2, 0, 0, is_br, 0, 0, 0, is_br);
    if (is_br) return;
    if (is_ld || is_st) begin
      n = (dw > WAIT_MAX) ? WAIT_MAX + 1 : dw + 1;
      for (int k = 0; k < n; k++) begin
        rd = (k == dw);
        push(op, 1'($urandom), rd, 3'd3, 0, 0, is_st && rd, 0, is_ld, is_st, is_st && rd);
      end
      if (dw > WAIT_MAX) begin
        m_fault = 2'b11; m_halted = 1'b1; push_halt(op, tail);
        return;
      end
      if (is_st) return;
    end
    push(op, 1'($urandom), 1'($urandom), 3'd4, 0, 0, 1, 1, 0, 0, 1);
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    Op         = 7'd0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    Zero       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  // Applies the model's per-cycle inputs and records both instances' outputs mid-cycle
  task automatic play();
    obs_t  o;
    obs4_t o4;
    obs_q.delete();
    obs4_q.delete();
    foreach (trace[i]) begin
      Op         = trace[i].op;
      imem_ready = trace[i].ir;
      dmem_ready = trace[i].dr;
      Zero       = 1'($urandom);
      @(negedge clk);
      o.vec  = {State, IMemReq, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Retire, Fault};
      o.ret  = RetireCnt;
      o.cyc  = CycleCnt;
      o4.vec = {State4, IMemReq4, IRWrite4, PCWrite4, RegWrite4, MemRead4, MemWrite4, Retire4, Fault4};
      o4.ret = RetireCnt4;
      o4.cyc = CycleCnt4;
      obs_q.push_back(o);
      obs4_q.push_back(o4);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; Op = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({State, IMemReq, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Retire, Fault} !== 12'h100) begin
      bad++;
      $display("FAIL reset_strobes got=%h want=%h", {State, IMemReq, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Retire, Fault}, 12'h100);
    end
    total++;
    if (RetireCnt !== 32'd0 || CycleCnt !== 32'd0 || RetireCnt4 !== 4'd0 || CycleCnt4 !== 4'd0) begin
      bad++;
      $display("FAIL reset_counters got ret=%0d cyc=%0d ret4=%0d cyc4=%0d want all 0", RetireCnt, CycleCnt, RetireCnt4, CycleCnt4);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_st [16] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};
    int rw_cnt;
    do_reset();
    model_instr(OP_R, 0, 0, 0);
    model_instr(OP_LD, 0, 0, 0);
    model_instr(OP_ST, 0, 0, 0);
    model_instr(OP_BR, 0, 0, 0);
    foreach (trace[i]) begin trace[i].ir = 1'b1; trace[i].dr = 1'b1; end
    play();
    rw_cnt = 0;
    for (int i = 0; i < trace.size(); i++) begin
      total++;
      if (obs_q[i] !== trace[i].exp || obs4_q[i] !== trace[i].exp4) begin
        bad++;
        $display("FAIL basic cyc%0d got=%h/%h want=%h/%h", i, obs_q[i], obs4_q[i], trace[i].exp, trace[i].exp4);
      end
      total++;
      if (i < 16 && obs_q[i].vec[11:9] !== exp_st[i]) begin
        bad++;
        $display("FAIL basic_state cyc%0d got=%0d want=%0d", i, obs_q[i].vec[11:9], exp_st[i]);
      end
      total++;
      if (obs_q[i].vec[5] && obs_q[i].vec[3]) begin
        bad++;
        $display("FAIL basic_rw_mw_overlap cyc%0d got=1 want=0", i);
      end
      rw_cnt += int'(obs_q[i].vec[5]);
    end
    total++;
    if (RetireCnt !== 32'd4 || CycleCnt !== 32'd16) begin
      bad++;
      $display("FAIL basic_counts got ret=%0d cyc=%0d want ret=4 cyc=16", RetireCnt, CycleCnt);
    end
    total++;
    if (rw_cnt !== 2) begin
      bad++;
      $display("FAIL basic_regwrite_count got=%0d want=2", rw_cnt);
    end
  endtask

  task automatic test_load_wait();
    int mr_cnt, mw_cnt, rw_cnt;
    do_reset();
    model_instr(OP_LD, 0, 3, 0);
    play();
    mr_cnt = 0; mw_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < trace.size(); i++) begin
      total++;
      if (obs_q[i] !== trace[i].exp || obs4_q[i] !== trace[i].exp4) begin
        bad++;
        $display("FAIL load_wait cyc%0d got=%h/%h want=%h/%h", i, obs_q[i], obs4_q[i], trace[i].exp, trace[i].exp4);
      end
      mr_cnt += int'(obs_q[i].vec[4]);
      mw_cnt += int'(obs_q[i].vec[3]);
      rw_cnt += int'(obs_q[i].vec[5]);
    end
    total++;
    if (mr_cnt !== 4 || mw_cnt !== 0 || rw_cnt !== 1) begin
      bad++;
      $display("FAIL load_wait_strobes got mr=%0d mw=%0d rw=%0d want mr=4 mw=0 rw=1", mr_cnt, mw_cnt, rw_cnt);
    end
    total++;
    if (obs_q[7].vec[11:9] !== 3'd4 || obs_q[7].vec[5] !== 1'b1) begin
      bad++;
      $display("FAIL load_wait_wb got state=%0d rw=%b want state=4 rw=1", obs_q[7].vec[11:9], obs_q[7].vec[5]);
    end
  endtask

  task automatic test_imem_timeout();
    do_reset();
    model_instr(OP_R, WAIT_MAX + 1, 0, 5);
    play();
    for (int i = 0; i < trace.size(); i++) begin
      total++;
      if (obs_q[i] !== trace[i].exp || obs4_q[i] !== trace[i].exp4) begin
        bad++;
        $display("FAIL imem_timeout cyc%0d got=%h/%h want=%h/%h", i, obs_q[i], obs4_q[i], trace[i].exp, trace[i].exp4);
      end
    end
    total++;
    if (obs_q[16].vec[11:9] !== 3'd5 || obs_q[16].vec[1:0] !== 2'b10 || obs_q[16].vec[8] !== 1'b0 || obs_q[20].cyc !== 32'd16) begin
      bad++;
      $display("FAIL imem_timeout_halt got state=%0d fault=%b imreq=%b cyc=%0d want state=5 fault=10 imreq=0 cyc=16",
               obs_q[16].vec[11:9], obs_q[16].vec[1:0], obs_q[16].vec[8], obs_q[20].cyc);
    end
  endtask

  task automatic test_imem_edge();
    do_reset();
    model_instr(OP_R, WAIT_MAX, 0, 0);
    play();
    for (int i = 0; i < trace.size(); i++) begin
      total++;
      if (obs_q[i] !== trace[i].exp || obs4_q[i] !== trace[i].exp4) begin
        bad++;
        $display("FAIL imem_edge cyc%0d got=%h/%h want=%h/%h", i, obs_q[i], obs4_q[i], trace[i].exp, trace[i].exp4);
      end
    end
    total++;
    if (obs_q[16].vec[11:9] !== 3'd1 || obs_q[16].vec[1:0] !== 2'b00) begin
      bad++;
      $display("FAIL imem_edge_id got state=%0d fault=%b want state=1 fault=00", obs_q[16].vec[11:9], obs_q[16].vec[1:0]);
    end
  endtask

  task automatic test_illegal();
    int pcw_cnt;
    do_reset();
    model_instr(OP_R, 0, 0, 0);
    model_instr(OP_BAD, 0, 0, 4);
    play();
    pcw_cnt = 0;
    for (int i = 0; i < trace.size(); i++) begin
      total++;
      if (obs_q[i] !== trace[i].exp || obs4_q[i] !== trace[i].exp4) begin
        bad++;
        $display("FAIL illegal cyc%0d got=%h/%h want=%h/%h", i, obs_q[i], obs4_q[i], trace[i].exp, trace[i].exp4);
      end
      pcw_cnt += int'(obs_q[i].vec[6]);
    end
    total++;
    if (pcw_cnt !== 1 || RetireCnt !== 32'd1 || Fault !== 2'b01 || State !== 3'd5) begin
      bad++;
      $display("FAIL illegal_halt got pcw=%0d ret=%0d fault=%b state=%0d want pcw=1 ret=1 fault=01 state=5",
               pcw_cnt, RetireCnt, Fault, State);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    Op = OP_ST; imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (State !== 3'd3 || MemWrite !== 1'b1 || CycleCnt !== 32'd3) begin
      bad++;
      $display("FAIL async_pre got state=%0d mw=%b cyc=%0d want state=3 mw=1 cyc=3", State, MemWrite, CycleCnt);
    end
    #2 rstn = 1'b0;
    #1;
    total++;
    if (State !== 3'd0 || MemWrite !== 1'b0 || IMemReq !== 1'b1 || Fault !== 2'b00 || CycleCnt !== 32'd0 || RetireCnt !== 32'd0) begin
      bad++;
      $display("FAIL async_reset got state=%0d mw=%b imreq=%b fault=%b cyc=%0d ret=%0d want state=0 mw=0 imreq=1 fault=00 cyc=0 ret=0",
               State, MemWrite, IMemReq, Fault, CycleCnt, RetireCnt);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    model_instr(OP_ST, 1, 2, 0);
    play();
    for (int i = 0; i < trace.size(); i++) begin
      total++;
      if (obs_q[i] !== trace[i].exp || obs4_q[i] !== trace[i].exp4) begin
        bad++;
        $display("FAIL async_restart cyc%0d got=%h/%h want=%h/%h", i, obs_q[i], obs4_q[i], trace[i].exp, trace[i].exp4);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (16) model_instr(OP_BR, 0, 0, 0);
    play();
    for (int i = 0; i < trace.size(); i++) begin
      total++;
      if (obs_q[i] !== trace[i].exp || obs4_q[i] !== trace[i].exp4) begin
        bad++;
        $display("FAIL wrap cyc%0d got=%h/%h want=%h/%h", i, obs_q[i], obs4_q[i], trace[i].exp, trace[i].exp4);
      end
    end
    total++;
    if (obs4_q[47].ret !== 4'd15 || RetireCnt4 !== 4'd0 || Fault4 !== 2'b00 || RetireCnt !== 32'd16) begin
      bad++;
      $display("FAIL wrap_counter got pre=%0d ret4=%0d fault4=%b ret=%0d want pre=15 ret4=0 fault4=00 ret=16",
               obs4_q[47].ret, RetireCnt4, Fault4, RetireCnt);
    end
  endtask

  task automatic test_random();
    logic [6:0] op;
    int iw, dw;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      repeat (30) begin
        op = LEGAL_OPS[$urandom_range(0, 7)];
        iw = ($urandom_range(0, 7) == 0) ? WAIT_MAX : int'($urandom_range(0, 3));
        dw = ($urandom_range(0, 7) == 0) ? WAIT_MAX : int'($urandom_range(0, 3));
        model_instr(op, iw, dw, 0);
      end
      case (r)
        0:       model_instr(OP_BAD, 1, 0, 3);
        1:       model_instr(OP_I, WAIT_MAX + 1, 0, 3);
        2:       model_instr(OP_LD, 0, WAIT_MAX + 1, 3);
        default: model_instr(OP_ST, 2, WAIT_MAX + 1, 3);
      endcase
      play();
      for (int i = 0; i < trace.size(); i++) begin
        total++;
        if (obs_q[i] !== trace[i].exp || obs4_q[i] !== trace[i].exp4) begin
          bad++;
          $display("FAIL random r%0d cyc%0d got=%h/%h want=%h/%h", r, i, obs_q[i], obs4_q[i], trace[i].exp, trace[i].exp4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_wait();
    test_imem_timeout();
    test_imem_edge();
    test_illegal();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
